// File: rtl/regfile_pkg.sv
// Shared types for the register-file write scheduler: register address and write request.
package regfile_pkg;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;
    localparam int DW     = 32;

    typedef logic [DW-1:0]     word_t;
    typedef logic [REG_AW-1:0] regaddr_t;

    typedef struct packed {
        regaddr_t addr;
        word_t    data;
    } wreq_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);
    logic          hit_hi;
    logic          hit_any;
    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_any;

    // Descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        hit_hi  = 1'b0;
        hit_any = 1'b0;
        idx_hi  = '0;
        idx_any = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                hit_any = 1'b1;
                idx_any = IW'(i);
                if (IW'(i) >= ptr) begin
                    hit_hi = 1'b1;
                    idx_hi = IW'(i);
                end
            end
        end
        gnt_idx = hit_hi ? idx_hi : idx_any;
        gnt     = hit_any ? (NREQ'(1) << gnt_idx) : '0;
    end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register file write port among NREQ writeback sources and tracks
// outstanding destination registers in a busy scoreboard.
module regfile_write_scheduler #(
    parameter int NREQ  = 2,
    parameter int DW    = regfile_pkg::DW,
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic [NREQ-1:0]                          req_valid,
    output logic [NREQ-1:0]                          req_ready,
    input  logic [NREQ-1:0][regfile_pkg::REG_AW-1:0] req_addr,
    input  logic [NREQ-1:0][DW-1:0]                  req_data,
    input  logic                                     rsv_valid,
    input  logic [regfile_pkg::REG_AW-1:0]           rsv_addr,
    output logic                                     rsv_ready,
    output logic [DW-1:0]                            wdat,
    output logic [NREGS-1:0]                         wen,
    output logic [NREGS-1:0]                         busy
);
    import regfile_pkg::regaddr_t;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [NREGS-1:0] wen_q, wen_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [DW-1:0]    wdat_q, wdat_d;

    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_idx;
    logic             accept;
    regaddr_t         acc_addr;

    // Nothing is granted while reset is asserted, so no write slips past reset.
    assign arb_req = req_valid & {NREQ{~RST}};

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (arb_req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign acc_addr  = req_addr[gnt_idx];

    assign rsv_ready = rsv_valid & ~RST &
                       ((rsv_addr == '0) | ~busy_q[rsv_addr]);

    always_comb begin
        ptr_d  = ptr_q;
        wen_d  = '0;
        wdat_d = wdat_q;
        if (accept) begin
            ptr_d  = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            wdat_d = req_data[gnt_idx];
            // $0 writes are consumed but never reach the array.
            if (acc_addr != '0)
                wen_d[acc_addr] = 1'b1;
        end
    end

    // Clear on the edge that commits the write; a same-edge reservation wins.
    always_comb begin
        busy_d = busy_q & ~wen_q;
        if (rsv_ready && rsv_addr != '0)
            busy_d[rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q  <= '0;
            wen_q  <= '0;
            wdat_q <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            wdat_q <= wdat_d;
            busy_q <= busy_d;
        end
    end

    assign wen  = wen_q;
    assign wdat = wdat_q;
    assign busy = busy_q;
endmodule
